// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {instr, pc4} pairs between fetch and decode.
// Valid/ready on both sides; a synchronous flush discards everything on a redirect.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc4,
  output logic              in_ready,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc4,
  input  logic              out_ready,
  input  logic              flush,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Empty queue presents a nop so decode never sees stale data.
  assign out_instr = out_valid ? mem[rd_ptr][63:32] : 32'h0;
  assign out_pc4   = out_valid ? mem[rd_ptr][31:0]  : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + ONE;
      else if (pop && !push) count_q <= count_q - ONE;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {in_instr, in_pc4};
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a reference queue of expected {instr, pc4} entries.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc4 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];

  if_id_queue #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc4(in_pc4), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc4(out_pc4), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the reference queue, which holds expected contents.
  task automatic check_state(input string tag);
    logic [63:0] head;
    head = (sb.size() > 0) ? sb[0] : 64'h0;
    chk({tag, "_count"},     {61'h0, count},     64'(sb.size()));
    chk({tag, "_out_valid"}, {63'h0, out_valid}, {63'h0, sb.size() > 0});
    chk({tag, "_in_ready"},  {63'h0, in_ready},  {63'h0, sb.size() < 4});
    chk({tag, "_head"},      {out_instr, out_pc4}, head);
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance reference, step to edge+1.
  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic r, input logic f, input string tag);
    bit do_pop, do_push;
    in_valid = v; in_instr = i; in_pc4 = p; out_ready = r; flush = f;
    check_state(tag);
    if (f) sb.delete();
    else begin
      do_pop  = r && (sb.size() > 0);
      do_push = v && (sb.size() < 4);
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back({i, p});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_count", {61'h0, count}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_head", {out_instr, out_pc4}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single entry in and out
    cyc(1, 32'h3c011234, 32'h00003004, 0, 0, "single_push");
    chk("single_instr", {32'h0, out_instr}, {32'h0, 32'h3c011234});
    chk("single_pc4", {32'h0, out_pc4}, {32'h0, 32'h00003004});
    cyc(0, 0, 0, 1, 0, "single_pop");
    cyc(0, 0, 0, 0, 0, "single_empty");

    // Fill, overflow attempt, ordered drain
    for (int k = 0; k < 4; k++)
      cyc(1, 32'h20010000 + 32'(k), 32'h3004 + 32'(4 * k), 0, 0, "fill");
    chk("full_in_ready", {63'h0, in_ready}, 64'h0);
    cyc(1, 32'hdeadbeef, 32'h3014, 0, 0, "full_reject");
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc4", {32'h0, out_pc4}, 64'(32'h3004 + 32'(4 * k)));
      cyc(0, 0, 0, 1, 0, "drain");
    end
    cyc(0, 0, 0, 0, 0, "drained");

    // Full with simultaneous pop: push rejected, count drops to 3
    for (int k = 0; k < 4; k++)
      cyc(1, 32'h24020000 + 32'(k), 32'h4004 + 32'(4 * k), 0, 0, "refill");
    cyc(1, 32'hcafef00d, 32'h4014, 1, 0, "full_pop");
    chk("full_pop_count", {61'h0, count}, 64'h3);
    cyc(0, 0, 0, 1, 0, "trim");

    // Steady stream at count=2, wrapping pointers
    for (int k = 0; k < 10; k++)
      cyc(1, 32'h8c000000 + 32'(k), 32'h5004 + 32'(4 * k), 1, 0, "stream");
    chk("stream_count", {61'h0, count}, 64'h2);
    cyc(0, 0, 0, 1, 0, "stream_drain");
    cyc(0, 0, 0, 1, 0, "stream_drain");
    cyc(0, 0, 0, 0, 0, "stream_empty");

    // Flush priority over push and pop
    for (int k = 0; k < 3; k++)
      cyc(1, 32'h00851020 + 32'(k), 32'h6004 + 32'(4 * k), 0, 0, "pre_flush");
    cyc(1, 32'h0c000c00, 32'h6010, 1, 1, "flush");
    chk("flush_count", {61'h0, count}, 64'h0);
    chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
    cyc(1, 32'h10220003, 32'h7004, 0, 0, "post_flush_push");
    chk("post_flush_head", {out_instr, out_pc4}, {32'h10220003, 32'h7004});
    cyc(0, 0, 0, 1, 0, "post_flush_pop");

    // Asynchronous reset between edges
    for (int k = 0; k < 3; k++)
      cyc(1, 32'h34420000 + 32'(k), 32'h8004 + 32'(4 * k), 0, 0, "pre_reset");
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_reset_count", {61'h0, count}, 64'h3);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    chk("async_count", {61'h0, count}, 64'h0);
    chk("async_out_valid", {63'h0, out_valid}, 64'h0);
    chk("async_head", {out_instr, out_pc4}, 64'h0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    cyc(1, 32'h00000000, 32'h00003004, 0, 0, "after_reset_push");
    chk("after_reset_pc4", {32'h0, out_pc4}, 64'h3004);
    cyc(0, 0, 0, 1, 0, "after_reset_pop");
    cyc(0, 0, 0, 0, 0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Instruction queue between the IFU and the decode/control stage of the pipelined MIPS core. Buffers {Instr, PC4} pairs produced by the fetch stage so fetch can run ahead of a stalled decode stage. Delivers them to decode in program order through a valid/ready handshake. A flush input discards all buffered entries on a taken beq, jal or jr redirect.

Parameters:
DEPTH, 4, number of entries; must be a power of 2 and at least 2
ADDR_W, 2, pointer width, equal to log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears the queue immediately
in_valid  input  1  fetch stage presents a valid instruction
in_instr  input  32  instruction word from the IFU
in_pc4  input  32  PC+4 of that instruction from the IFU
in_ready  output  1  queue can accept an entry this cycle
out_valid  output  1  head entry is valid
out_instr  output  32  head instruction word
out_pc4  output  32  head PC+4
out_ready  input  1  decode consumes the head this cycle
flush  input  1  synchronous discard of all entries (branch/jump redirect)
count  output  ADDR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries, 64 bits each ({instr, pc4}).
- Pointers: wr_ptr and rd_ptr, ADDR_W bits each, plus a count register of ADDR_W+1 bits.
- Pointers wrap modulo DEPTH; there is no special case at the wrap point.
- Reset (asynchronous, active-high): wr_ptr=0, rd_ptr=0, count=0, takes effect without a clock edge.
  - Outputs during and after reset: out_valid=0, in_ready=1, count=0, out_instr=0, out_pc4=0.
  - Storage array contents are not reset.
- in_ready = (count != DEPTH). It is purely a function of registered count and does not depend on out_ready.
- out_valid = (count != 0).
- out_instr and out_pc4 show mem[rd_ptr] when out_valid=1. They are forced to 32'h0 when out_valid=0, so decode sees a nop (sll $0,$0,0).
- Push: in_valid & in_ready at the rising edge writes mem[wr_ptr] and increments wr_ptr.
- Pop: out_valid & out_ready at the rising edge increments rd_ptr.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
- Latency: an entry pushed at edge N is visible on out_* after edge N; it can be popped at edge N+1 at the earliest.
- No bypass when empty: if empty with in_valid=1 and out_ready=1, the entry is written and out_valid stays 0 until after the edge.
- Full: in_valid is ignored (no write, no pointer change), even if a pop happens in the same cycle. Fetch must hold its instruction and PC.
- Flush: at the edge, wr_ptr=rd_ptr=0 and count=0.
  - Flush takes priority over any push or pop in the same cycle; the instruction offered that cycle is dropped.
  - From the cycle after flush: out_valid=0, in_ready=1.
- Reset asserted mid-operation: all entries are lost at once, with the same outputs as the reset state. Operation resumes at the first rising edge after reset deasserts.
- No overflow or underflow is possible through the handshake; the queue never writes when full or pops when empty.
- The queue does not inspect the instruction; it carries 32-bit data through unchanged.

Test Plan:
- Reset then single entry: push instr 32'h3c011234, pc4 32'h00003004 → one cycle later out_valid=1, out_instr=32'h3c011234, out_pc4=32'h00003004, count=1; pop → count=0, out_instr=0.
- Fill and order: push 4 entries (pc4 32'h3004, 3008, 300c, 3010) with out_ready=0 → count=4, in_ready=0. A 5th push with in_valid=1 is ignored. Popping 4 times returns pc4 in order 3004, 3008, 300c, 3010.
- Simultaneous push and pop: steady stream with in_valid=1 and out_ready=1 from count=2 for 10 cycles → count stays 2, pointers wrap past DEPTH, all 10 pc4 values come out in order with none dropped.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 → pop happens, push is rejected, count=3 next cycle.
- Flush priority: count=3, flush=1 with in_valid=1 (instr 32'h0c000c00) and out_ready=1 → next cycle count=0, out_valid=0, in_ready=1; the next push shows up as the head.
- Async reset mid-stream: count=3, assert reset between clock edges → count=0 and out_valid=0 before the next edge. After deassert, push 32'h00000000 / 32'h3004 and it pops normally.
